cpu8_core: RTL and testbench
============================

Name: cpu8_core

Overview:
- 8-bit single-cycle load/store processor core with 4×8-bit register file, 4×8-bit data memory, PC, ALU, and 7-segment decoders for board display.
- Instruction memory is an external combinational ROM. The core drives `read_address` and receives `instruction` in the same cycle.
- A clock divider derives the processor clock `clk_out` from `clk_in`.
- Internal state is exported for debug and LEDs.

Parameters:
- CLK_DIV, 1, number of `clk_in` rising edges between `clk_out` toggles (≥1).

Ports:
- clk_in  input  1  board clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- instruction  input  8  instruction from external IMEM at `read_address`.
- read_address  output  8  program counter.
- clk_out  output  1  divided processor clock.
- neg_clk_out  output  1  ~clk_out.
- programcounter_one / programcounter_sixteen  output  7  segments for PC[3:0] / PC[7:4].
- data_one / data_sixteen  output  7  segments for write-back data [3:0] / [7:4].
- register0..register3  output  8  register file contents.
- mem0..mem3  output  8  data memory contents.
- reg_write, reg_dst, mem_read, alu_src  output  1  decoded control signals.
- write_register  output  2  destination register index.
- mem_read_data  output  8  data memory read value.
- alu_out  output  8  ALU result.
- reg_read_data1  output  8  register[rs].
- sign_extend  output  8  sign-extended immediate.
- alu_input2_mux  output  8  second ALU operand.
- write_now  output  1  high when a register or memory write commits this cycle (reg_write | mem_write).
- instruction_sixteen / instruction_one  output  1  |instruction[7:4] / |instruction[3:0] (nibble-nonzero LEDs).

Behaviour:
- Instruction format: op[7:6], rs[5:4], rt[3:2], rd/imm[1:0]. Jump target is [5:0].
- Opcodes:
  - 00 ADD: rd = rs + rt (mod 256); reg_dst=1, reg_write=1, alu_src=0.
  - 01 LW: rt = dmem[(rs + sext(imm))[1:0]]; mem_read=1, reg_write=1, alu_src=1, reg_dst=0.
  - 10 SW: dmem[(rs + sext(imm))[1:0]] = rt; alu_src=1, no register write.
  - 11 J: PC = {(PC+1)[7:6], instruction[5:0]}. All write enables 0.
- sign_extend = {{6{imm[1]}}, imm}.
- write_register = reg_dst ? rd : rt.
- Write-back data = mem_read ? mem_read_data : alu_out.
- alu_input2_mux = alu_src ? sign_extend : register[rt].
- Data memory address uses alu_out[1:0] (wraps modulo 4). mem_read_data is a combinational read.
- Clock divider: counter on `clk_in` rising edge. `clk_out` toggles when the count reaches CLK_DIV-1, then the counter clears.
- All architectural state (PC, registers, dmem) updates on the `clk_out` rising edge. One instruction per `clk_out` period.
- PC increments by 1 per instruction, wrapping 0xFF→0x00, except J.
- Simultaneous register read/write of the same index: read returns the old value within the cycle.
- Reset (low, asynchronous, any time including mid-instruction):
  - PC=0x00, clk_out=0, divider count=0.
  - register0..3 = 0,1,2,3; mem0..3 = 0,1,2,3.
  - State holds while reset is low; execution resumes at PC 0 on the first `clk_out` rising edge after release.
- 7-segment encoding is {g,f,e,d,c,b,a}, active-low, hex 0–F. Examples: 0→0x40, 1→0x79, 2→0x24, 3→0x30, A→0x08, F→0x0E.

Optional Feature:
- CPU8_SEG_ACTIVE_HIGH_EN.
  - Defined: all 7-segment outputs are inverted (active-high; 0→0x3F).
  - Undefined: active-low encoding as above.

Decomposition:
- Package cpu8_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11;
  - reset-value constants for registers and memory;
  - the 16-entry segment table.
- Sub-module hex_to_7seg (4-bit in, 7-bit out), instantiated four times.

Test Plan:
- Reset low, then release → PC=0x00; register0..3=0,1,2,3; mem0..3=0,1,2,3; programcounter_one=0x40. Assert reset mid-run → PC returns to 0x00 immediately, without waiting for a clock.
- ADD 0x1B at PC 0 → register3=0x03, write_register=3, reg_dst=1, write_now=1; PC=0x01 after the edge.
- LW 0x70 (r0=mem[r3+0]) → mem_read=1, alu_out=0x03, mem_read_data=0x03, register0=0x03, data_one=0x30.
- SW 0x98 (mem[r1]=r2) → mem1=0x02, reg_write=0, write_now=1, registers unchanged.
- LW 0x46 (imm=2'b10, sext=0xFE, rs=r0=0) → alu_out=0xFE, address wraps to 2, register1=mem2=0x02.
- J 0xC5 at PC 0x03 → PC=0x05, no state write. Run 256 non-jump instructions → PC wraps 0xFF→0x00. With CLK_DIV=3, the `clk_out` period is 6 `clk_in` cycles.

Source files
------------

// File: rtl/cpu8_core_pkg.sv
// ============================================================================
// Module  : cpu8_pkg
// Purpose : Shared constants, control-word type and helpers for cpu8_core.
//           Holds opcodes, reset contents of registers/memory and the
//           active-low 7-segment table ({g,f,e,d,c,b,a}).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu8_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Packed as {entry3, entry2, entry1, entry0}
  localparam logic [3:0][7:0] REG_RESET = {8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [3:0][7:0] MEM_RESET = {8'd3, 8'd2, 8'd1, 8'd0};

  // Active-low segment patterns, index 0 is the rightmost entry
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic reg_write;
    logic reg_dst;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic jump;
  } ctrl_t;

  // Opcode to control-word decode
  function automatic ctrl_t decode(input logic [1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      OP_LW:  begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; end
      OP_SW:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      default: c.jump = 1'b1;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu8_core_if.sv
// ============================================================================
// Module  : cpu8_core_if
// Purpose : Instruction-memory bus between the core (master) and the
//           external combinational ROM (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu8_core_if;
  logic [7:0] read_address;
  logic [7:0] instruction;

  modport master (output read_address, input instruction);
  modport slave  (input read_address, output instruction);
endinterface

`default_nettype wire

// File: rtl/cpu8_core_hex_to_7seg.sv
// ============================================================================
// Module  : hex_to_7seg
// Purpose : 4-bit hex digit to 7-segment pattern {g,f,e,d,c,b,a}.
//           Active-low by default; CPU8_SEG_ACTIVE_HIGH_EN inverts output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_7seg
  import cpu8_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup with optional polarity inversion
  always_comb begin
`ifdef CPU8_SEG_ACTIVE_HIGH_EN
    seg_o = ~SEG_TABLE[hex_i];
`else
    seg_o = SEG_TABLE[hex_i];
`endif
  end

endmodule

`default_nettype wire

// File: rtl/cpu8_core.sv
// ============================================================================
// Module  : cpu8_core
// Purpose : 8-bit single-cycle load/store core. Architectural state commits
//           on the clk_in edge where the divided clk_out rises, so the whole
//           design lives in the clk_in domain. Segment polarity selectable
//           with CPU8_SEG_ACTIVE_HIGH_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu8_core
  import cpu8_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  cpu8_core_if.master      imem,
  output logic             clk_out,
  output logic             neg_clk_out,
  output logic [6:0]       programcounter_one,
  output logic [6:0]       programcounter_sixteen,
  output logic [6:0]       data_one,
  output logic [6:0]       data_sixteen,
  output logic [7:0]       register0,
  output logic [7:0]       register1,
  output logic [7:0]       register2,
  output logic [7:0]       register3,
  output logic [7:0]       mem0,
  output logic [7:0]       mem1,
  output logic [7:0]       mem2,
  output logic [7:0]       mem3,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_read,
  output logic             alu_src,
  output logic [1:0]       write_register,
  output logic [7:0]       mem_read_data,
  output logic [7:0]       alu_out,
  output logic [7:0]       reg_read_data1,
  output logic [7:0]       sign_extend,
  output logic [7:0]       alu_input2_mux,
  output logic             write_now,
  output logic             instruction_sixteen,
  output logic             instruction_one
);

  localparam int         CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          clk_out_q;
  logic [7:0]    pc_q, pc_d, pc_inc;
  logic [7:0]    regs_q [4];
  logic [7:0]    mems_q [4];

  logic [7:0]    instr;
  logic [1:0]    rs, rt, rd;
  ctrl_t         ctrl;
  logic [7:0]    rt_val, wb_data;
  logic          tick;

  assign instr = imem.instruction;
  assign rs    = instr[5:4];
  assign rt    = instr[3:2];
  assign rd    = instr[1:0];

  // A commit happens on the clk_in edge that raises clk_out
  assign tick = (cnt_q == CNT_MAX) && !clk_out_q;

  // Instruction decode and datapath
  always_comb begin
    ctrl           = decode(instr[7:6]);
    reg_read_data1 = regs_q[rs];
    rt_val         = regs_q[rt];
    sign_extend    = {{6{rd[1]}}, rd};
    alu_input2_mux = ctrl.alu_src ? sign_extend : rt_val;
    alu_out        = reg_read_data1 + alu_input2_mux;
    mem_read_data  = mems_q[alu_out[1:0]];
    wb_data        = ctrl.mem_read ? mem_read_data : alu_out;
    write_register = ctrl.reg_dst ? rd : rt;
    pc_inc         = pc_q + 8'd1;
    pc_d           = ctrl.jump ? {pc_inc[7:6], instr[5:0]} : pc_inc;
  end

  // Clock divider: toggle clk_out every CLK_DIV clk_in edges
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q     <= '0;
      clk_out_q <= ~clk_out_q;
    end else begin
      cnt_q     <= cnt_q + CW'(1);
    end
  end

  // Architectural state: PC, register file, data memory
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pc_q <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= REG_RESET[i];
        mems_q[i] <= MEM_RESET[i];
      end
    end else if (tick) begin
      pc_q <= pc_d;
      if (ctrl.reg_write) regs_q[write_register] <= wb_data;
      if (ctrl.mem_write) mems_q[alu_out[1:0]]   <= rt_val;
    end
  end

  assign imem.read_address   = pc_q;
  assign clk_out             = clk_out_q;
  assign neg_clk_out         = ~clk_out_q;
  assign register0           = regs_q[0];
  assign register1           = regs_q[1];
  assign register2           = regs_q[2];
  assign register3           = regs_q[3];
  assign mem0                = mems_q[0];
  assign mem1                = mems_q[1];
  assign mem2                = mems_q[2];
  assign mem3                = mems_q[3];
  assign reg_write           = ctrl.reg_write;
  assign reg_dst             = ctrl.reg_dst;
  assign mem_read            = ctrl.mem_read;
  assign alu_src             = ctrl.alu_src;
  assign write_now           = ctrl.reg_write | ctrl.mem_write;
  assign instruction_sixteen = |instr[7:4];
  assign instruction_one     = |instr[3:0];

  hex_to_7seg u_seg_pc_lo   (.hex_i(pc_q[3:0]),    .seg_o(programcounter_one));
  hex_to_7seg u_seg_pc_hi   (.hex_i(pc_q[7:4]),    .seg_o(programcounter_sixteen));
  hex_to_7seg u_seg_data_lo (.hex_i(wb_data[3:0]), .seg_o(data_one));
  hex_to_7seg u_seg_data_hi (.hex_i(wb_data[7:4]), .seg_o(data_sixteen));

endmodule

`default_nettype wire

// File: tb/tb_cpu8_core.sv
// ============================================================================
// Module  : tb_cpu8_core
// Purpose : Directed self-checking bench for cpu8_core with CLK_DIV=3.
//           Pre-edge checks on decoded signals; post-edge state taken from
//           a scoreboard queue filled when each instruction is presented.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu8_core;
  import cpu8_pkg::*;

  localparam int CLK_DIV = 3;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  cpu8_core_if bus ();

  logic       clk_out, neg_clk_out;
  logic [6:0] programcounter_one, programcounter_sixteen, data_one, data_sixteen;
  logic [7:0] register0, register1, register2, register3;
  logic [7:0] mem0, mem1, mem2, mem3;
  logic       reg_write, reg_dst, mem_read, alu_src, write_now;
  logic [1:0] write_register;
  logic [7:0] mem_read_data, alu_out, reg_read_data1, sign_extend, alu_input2_mux;
  logic       instruction_sixteen, instruction_one;

  logic [7:0] rom [256];

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] regs;
    logic [31:0] mems;
  } exp_t;
  exp_t sb [$];

  int vectors    = 0;
  int miscompares = 0;
  longint t1, t2;

  always #5 clk_in = ~clk_in;

  // External combinational instruction ROM
  always_comb bus.instruction = rom[bus.read_address];

  cpu8_core #(.CLK_DIV(CLK_DIV)) dut (
    .clk_in(clk_in), .reset(reset), .imem(bus),
    .clk_out(clk_out), .neg_clk_out(neg_clk_out),
    .programcounter_one(programcounter_one), .programcounter_sixteen(programcounter_sixteen),
    .data_one(data_one), .data_sixteen(data_sixteen),
    .register0(register0), .register1(register1), .register2(register2), .register3(register3),
    .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_read(mem_read), .alu_src(alu_src),
    .write_register(write_register), .mem_read_data(mem_read_data), .alu_out(alu_out),
    .reg_read_data1(reg_read_data1), .sign_extend(sign_extend),
    .alu_input2_mux(alu_input2_mux), .write_now(write_now),
    .instruction_sixteen(instruction_sixteen), .instruction_one(instruction_one)
  );

  function automatic logic [6:0] sx(input logic [6:0] v);
`ifdef CPU8_SEG_ACTIVE_HIGH_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] regs_now();
    return {register3, register2, register1, register0};
  endfunction

  function automatic logic [31:0] mems_now();
    return {mem3, mem2, mem1, mem0};
  endfunction

  task automatic push_exp(input logic [7:0] pc, input logic [31:0] r, input logic [31:0] m);
    exp_t e;
    e.pc = pc; e.regs = r; e.mems = m;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pc"},   {24'd0, bus.read_address}, {24'd0, e.pc});
      chk({tag, "_regs"}, regs_now(), e.regs);
      chk({tag, "_mems"}, mems_now(), e.mems);
    end
  endtask

  // Wait (bounded) for a clk_out rising edge; returns #1 after it
  task automatic wait_rise();
    bit   seen;
    logic prev;
    seen = 1'b0;
    prev = clk_out;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk_in);
      #1;
      if (!prev && clk_out) seen = 1'b1;
      prev = clk_out;
    end
    if (!seen) chk("clk_out_rise_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h1B;  // ADD r3 = r1 + r2
    rom[1] = 8'h70;  // LW  r0 = mem[r3 + 0]
    rom[2] = 8'h98;  // SW  mem[r1 + 0] = r2
    rom[3] = 8'hC5;  // J   0x05
    rom[4] = 8'h1F;  // skipped
    rom[5] = 8'h76;  // LW  r1 = mem[r3 + sext(2'b10)]
    rom[6] = 8'h3E;  // ADD r2 = r3 + r3
    rom[7] = 8'h65;  // LW  r1 = mem[(r2 + 1) mod 4]

    // Reset state
    #23;
    chk("rst_pc",     {24'd0, bus.read_address}, 32'h00);
    chk("rst_regs",   regs_now(), 32'h03020100);
    chk("rst_mems",   mems_now(), 32'h03020100);
    chk("rst_pcseg",  {25'd0, programcounter_one}, {25'd0, sx(7'h40)});
    chk("rst_clkout", {30'd0, clk_out, neg_clk_out}, 32'b01);
    @(negedge clk_in);
    reset = 1'b1;
    #1;

    // PC0 ADD 0x1B
    chk("add_wreg",   {30'd0, write_register}, 32'd3);
    chk("add_ctl",    {28'd0, reg_dst, reg_write, alu_src, write_now}, 32'b1101);
    chk("add_alu",    {24'd0, alu_out}, 32'h03);
    chk("add_op2",    {24'd0, alu_input2_mux}, 32'h02);
    chk("add_nib",    {30'd0, instruction_sixteen, instruction_one}, 32'b11);
    push_exp(8'h01, 32'h03020100, 32'h03020100);
    wait_rise();
    t1 = $time;
    pop_chk("add");

    // PC1 LW 0x70
    chk("lw_ctl",     {29'd0, mem_read, alu_src, reg_dst}, 32'b110);
    chk("lw_alu",     {24'd0, alu_out}, 32'h03);
    chk("lw_mrd",     {24'd0, mem_read_data}, 32'h03);
    chk("lw_wreg",    {30'd0, write_register}, 32'd0);
    chk("lw_dseg",    {18'd0, data_sixteen, data_one}, {18'd0, sx(7'h40), sx(7'h30)});
    chk("lw_pcseg",   {25'd0, programcounter_one}, {25'd0, sx(7'h79)});
    push_exp(8'h02, 32'h03020103, 32'h03020100);
    wait_rise();
    t2 = $time;
    chk("clk_out_period", 32'(t2 - t1), 32'd60);
    pop_chk("lw");

    // PC2 SW 0x98
    chk("sw_ctl",     {29'd0, reg_write, write_now, mem_read}, 32'b010);
    chk("sw_alu",     {24'd0, alu_out}, 32'h01);
    push_exp(8'h03, 32'h03020103, 32'h03020200);
    wait_rise();
    pop_chk("sw");

    // PC3 J 0xC5
    chk("j_wnow",     {30'd0, write_now, reg_write}, 32'b00);
    push_exp(8'h05, 32'h03020103, 32'h03020200);
    wait_rise();
    pop_chk("j");

    // PC5 LW 0x76: negative immediate, ALU carry drops
    chk("lwn_sext",   {24'd0, sign_extend}, 32'hFE);
    chk("lwn_op2",    {24'd0, alu_input2_mux}, 32'hFE);
    chk("lwn_alu",    {24'd0, alu_out}, 32'h01);
    chk("lwn_mrd",    {24'd0, mem_read_data}, 32'h02);
    push_exp(8'h06, 32'h03020203, 32'h03020200);
    wait_rise();
    pop_chk("lwn");

    // PC6 ADD 0x3E
    chk("add2_alu",   {24'd0, alu_out}, 32'h06);
    chk("add2_wreg",  {30'd0, write_register}, 32'd2);
    push_exp(8'h07, 32'h03060203, 32'h03020200);
    wait_rise();
    pop_chk("add2");

    // PC7 LW 0x65: address 7 wraps to 3
    chk("lww_alu",    {24'd0, alu_out}, 32'h07);
    chk("lww_mrd",    {24'd0, mem_read_data}, 32'h03);
    chk("lww_wreg",   {30'd0, write_register}, 32'd1);
    push_exp(8'h08, 32'h03060303, 32'h03020200);
    wait_rise();
    pop_chk("lww");

    // Run sequential instructions up to PC 0xFF, then wrap
    for (int i = 0; i < 300 && bus.read_address != 8'hFF; i++) wait_rise();
    chk("wrap_reach_ff", {24'd0, bus.read_address}, 32'hFF);
    chk("wrap_pcseg_ff", {18'd0, programcounter_sixteen, programcounter_one},
        {18'd0, sx(7'h0E), sx(7'h0E)});
    chk("wrap_nib",   {30'd0, instruction_sixteen, instruction_one}, 32'b00);
    wait_rise();
    chk("wrap_pc_00", {24'd0, bus.read_address}, 32'h00);
    chk("wrap_pcseg_00", {25'd0, programcounter_one}, {25'd0, sx(7'h40)});

    // Mid-instruction asynchronous reset
    wait_rise();
    repeat (2) @(posedge clk_in);
    #3;
    reset = 1'b0;
    #1;
    chk("mrst_pc",    {24'd0, bus.read_address}, 32'h00);
    chk("mrst_clk",   {31'd0, clk_out}, 32'd0);
    chk("mrst_regs",  regs_now(), 32'h03020100);
    chk("mrst_mems",  mems_now(), 32'h03020100);
    repeat (5) @(posedge clk_in);
    #1;
    chk("mrst_hold",  {23'd0, clk_out, bus.read_address}, 32'h000);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    chk("resume_alu", {24'd0, alu_out}, 32'h03);
    push_exp(8'h01, 32'h03020100, 32'h03020100);
    wait_rise();
    pop_chk("resume");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
